// File: rtl/hack_pkg.sv
// Shared constants, instruction field layout, field typedefs and FSM states
// for the Hack CPU commit stage.
package hack_pkg;

    localparam int unsigned HACK_WORD_W = 16;
    localparam int unsigned HACK_ADDR_W = 15;
    localparam int unsigned INSTRET_W   = 16;

    // Instruction field bit positions
    localparam int unsigned INSTR_C_BIT = 15;
    localparam int unsigned DEST_MSB    = 5;
    localparam int unsigned DEST_LSB    = 3;
    localparam int unsigned JUMP_MSB    = 2;
    localparam int unsigned JUMP_LSB    = 0;

    // Destination field: instr[5]=A, instr[4]=D, instr[3]=M
    typedef struct packed {
        logic a;
        logic d;
        logic m;
    } dest_t;

    // Jump field: instr[2]=lt, instr[1]=eq, instr[0]=gt
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } jump_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MEM_WR = 1'b1
    } wb_state_t;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump decision from the jump bits and ALU flags.
module hack_jump_cond
    import hack_pkg::*;
(
    input  jump_t jbits,
    input  logic  zr,
    input  logic  ng,
    output logic  take_c
);

    // Taken when any enabled condition matches the ALU result sign/zero
    always_comb begin
        take_c = (jbits.lt & ng) | (jbits.eq & zr) | (jbits.gt & ~ng & ~zr);
    end

endmodule

// File: rtl/hack_writeback.sv
// Hack CPU commit stage: owns A/D/PC, resolves jumps, and issues RAM[A]
// writes over a valid/ready port.
// Optional halt-loop detection is enabled by defining HACK_HALT_DETECT_EN.
module hack_writeback
    import hack_pkg::*;
#(
    parameter int unsigned WORD_W = HACK_WORD_W,
    parameter int unsigned ADDR_W = HACK_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    instr,
    input  logic [WORD_W-1:0]    alu_out,
    input  logic                 alu_zr,
    input  logic                 alu_ng,
    output logic [WORD_W-1:0]    a_reg,
    output logic [WORD_W-1:0]    d_reg,
    output logic [ADDR_W-1:0]    pc,
    output logic                 mem_wr_valid,
    input  logic                 mem_wr_ready,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [WORD_W-1:0]    mem_wr_data,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halted
);

    wb_state_t state;
    wb_state_t state_nxt;

    dest_t dest;
    jump_t jbits;
    logic  is_c_c;
    logic  take_c;
    logic  accept_c;
    logic  [ADDR_W-1:0] pc_inc_c;

    assign is_c_c   = instr[INSTR_C_BIT];
    assign dest     = dest_t'(instr[DEST_MSB:DEST_LSB]);
    assign jbits    = jump_t'(instr[JUMP_MSB:JUMP_LSB]);
    assign accept_c = in_valid & in_ready;
    assign pc_inc_c = pc + ADDR_W'(1);

    hack_jump_cond u_jump_cond (
        .jbits  (jbits),
        .zr     (alu_zr),
        .ng     (alu_ng),
        .take_c (take_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; a C-instr with dest M parks in MEM_WR
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = ~halted;
                if (in_valid && !halted && is_c_c && dest.m) begin
                    state_nxt = ST_MEM_WR;
                end
            end
            ST_MEM_WR: begin
                if (mem_wr_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem_wr_valid = (state == ST_MEM_WR);

    // Architectural state commit; every C-instr effect uses the pre-accept A
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg       <= '0;
            d_reg       <= '0;
            pc          <= '0;
            instret     <= '0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else if (accept_c) begin
            instret <= instret + INSTRET_W'(1);
            if (!is_c_c) begin
                a_reg <= WORD_W'(instr[WORD_W-2:0]);
                pc    <= pc_inc_c;
            end else begin
                if (dest.a) begin
                    a_reg <= alu_out;
                end
                if (dest.d) begin
                    d_reg <= alu_out;
                end
                if (dest.m) begin
                    mem_wr_addr <= a_reg[ADDR_W-1:0];
                    mem_wr_data <= alu_out;
                end
                pc <= take_c ? a_reg[ADDR_W-1:0] : pc_inc_c;
            end
        end
    end

`ifdef HACK_HALT_DETECT_EN
    logic self_jump_c;
    assign self_jump_c = accept_c & is_c_c & take_c & (a_reg[ADDR_W-1:0] == pc);

    // Sticky halt on a taken jump back to the current instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (self_jump_c) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_writeback.sv
// Self-checking bench for hack_writeback: directed scenarios plus random
// instruction streams compared against a behavioural model.
module tb_hack_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [14:0] pc;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [14:0] mem_wr_addr;
    logic [15:0] mem_wr_data;
    logic [15:0] instret;
    logic        halted;

`ifdef HACK_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model of the architectural state
    logic [15:0] m_a, m_d, m_instret, m_wdata;
    logic [14:0] m_pc, m_waddr;
    bit          m_pend, m_halted;

    hack_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .alu_out      (alu_out),
        .alu_zr       (alu_zr),
        .alu_ng       (alu_ng),
        .a_reg        (a_reg),
        .d_reg        (d_reg),
        .pc           (pc),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .instret      (instret),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_take(input logic [2:0] j, input logic [15:0] v);
        int s;
        s = $signed(v);
        return (j[2] && s < 0) || (j[1] && s == 0) || (j[0] && s > 0);
    endfunction

    task automatic model_reset();
        m_a = 0; m_d = 0; m_pc = 0; m_instret = 0;
        m_pend = 0; m_halted = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic model_accept(input logic [15:0] ins, input logic [15:0] alu);
        logic [15:0] old_a;
        bit tk;
        old_a = m_a;
        m_instret = m_instret + 16'd1;
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            tk = model_take(ins[2:0], alu);
            if (HALT_EN && tk && old_a[14:0] == m_pc) m_halted = 1;
            if (ins[5]) m_a = alu;
            if (ins[4]) m_d = alu;
            if (ins[3]) begin
                m_pend  = 1;
                m_waddr = old_a[14:0];
                m_wdata = alu;
            end
            m_pc = tk ? old_a[14:0] : m_pc + 15'd1;
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".a_reg"},    a_reg,        m_a);
        chk({t, ".d_reg"},    d_reg,        m_d);
        chk({t, ".pc"},       pc,           m_pc);
        chk({t, ".instret"},  instret,      m_instret);
        chk({t, ".wr_valid"}, mem_wr_valid, m_pend);
        chk({t, ".in_ready"}, in_ready,     !m_pend && !m_halted);
        chk({t, ".halted"},   halted,       m_halted);
        if (m_pend) begin
            chk({t, ".wr_addr"}, mem_wr_addr, m_waddr);
            chk({t, ".wr_data"}, mem_wr_data, m_wdata);
        end
    endtask

    task automatic drive(input logic [15:0] ins, input logic [15:0] alu);
        instr   = ins;
        alu_out = alu;
        alu_zr  = (alu == 16'h0);
        alu_ng  = alu[15];
    endtask

    // Offer one instruction for one cycle; accepted only if the model says ready
    task automatic issue(input string t, input logic [15:0] ins, input logic [15:0] alu);
        bit exp_rdy;
        exp_rdy = !m_pend && !m_halted;
        drive(ins, alu);
        in_valid = 1'b1;
        chk({t, ".ready_pre"}, in_ready, exp_rdy);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (exp_rdy) model_accept(ins, alu);
        check_all(t);
    endtask

    // Stall the write for n cycles (with junk offered upstream), optionally complete it
    task automatic drain(input string t, input int n, input bit complete);
        for (int i = 0; i < n; i++) begin
            mem_wr_ready = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            drive(16'($urandom), 16'($urandom));
            @(posedge clk);
            #1;
            check_all({t, ".stall"});
        end
        in_valid = 1'b0;
        if (complete) begin
            mem_wr_ready = 1'b1;
            @(posedge clk);
            #1;
            mem_wr_ready = 1'b0;
            m_pend = 0;
            check_all({t, ".done"});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        mem_wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] rins, ralu;
        int n;
        reset = 1'b0; in_valid = 1'b0; mem_wr_ready = 1'b0;
        drive(16'h0, 16'h0);

        // Reset state and A-instruction
        do_reset();
        check_all("reset");
        issue("a_instr", 16'h1234, 16'h0);

        // C-instr dest=D, no jump
        issue("dest_d", 16'hE010, 16'hBEEF);

        // dest=AMD with stalled write: address is old A
        issue("set_a100", 16'h0100, 16'h0);
        issue("dest_amd", 16'hE038, 16'h0042);
        drain("amd_wr", 3, 1'b1);

        // Jump conditions against A=0x0020
        issue("set_a20", 16'h0020, 16'h0);
        issue("jlt_ng", 16'hE004, 16'h8000);
        issue("jlt_zr", 16'hE004, 16'h0000);
        issue("jmp", 16'hE007, 16'h7123);
        issue("jeq_nz", 16'hE002, 16'h0005);
        issue("jgt_pos", 16'hE001, 16'h0001);

        // Random instruction stream with random write stalls
        for (int i = 0; i < 300 && !m_halted; i++) begin
            rins = 16'($urandom);
            ralu = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            issue("rand", rins, ralu);
            if (m_pend) drain("rand_wr", $urandom_range(0, 3), 1'b1);
        end

        // Back-to-back A-instrs up to the instret / pc wrap points
        do_reset();
        in_valid = 1'b1;
        n = 32'hFFFE - int'(m_instret);
        for (int i = 0; i < n; i++) begin
            drive({1'b0, 15'($urandom)}, 16'($urandom));
            @(posedge clk);
            #1;
            model_accept(instr, alu_out);
        end
        in_valid = 1'b0;
        check_all("bulk");
        issue("pre_wrap", 16'h0001, 16'h0);
        issue("wrap", 16'h0002, 16'h0);
        chk("wrap.pc_zero", pc, 32'h0);
        chk("wrap.instret_zero", instret, 32'h0);

        // Reset while a write is pending
        issue("set_a300", 16'h0300, 16'h0);
        issue("dest_m", 16'hE008, 16'h5555);
        drain("pend", 2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all("reset_mid_wr");

`ifdef HACK_HALT_DETECT_EN
        // Jump-to-self halts the stage
        for (int i = 0; i < 5; i++) issue("halt_setup", 16'h0005, 16'h0);
        issue("halt_jmp", 16'hE007, 16'h0000);
        chk("halt.flag", halted, 32'h1);
        issue("halt_blocked", 16'h0007, 16'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
